// File: rtl/grid_cursor_ctrl.sv
// Grid cursor controller: button edge detection, prioritised one-step moves with saturate/wrap, select capture.
// Optional auto-repeat on a held direction is compiled in with `define GRID_CURSOR_AUTOREPEAT_EN.
module grid_cursor_ctrl #(
    parameter int COLS = 3,
    parameter int ROWS = 4,
    parameter int XW   = 3,
    parameter int YW   = 4,
    parameter int IW   = 4,
    parameter int WRAP = 0
`ifdef GRID_CURSOR_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_sel,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic [IW-1:0] cursor_idx,
    output logic          moved,
    output logic          sel_pulse,
    output logic [IW-1:0] sel_idx
);

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    logic prev_up, prev_down, prev_left, prev_right, prev_sel;
    logic press_up, press_down, press_left, press_right, press_sel;

    dir_t          press_dir;
    dir_t          move_dir;
    logic          do_move;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic [IW-1:0] next_idx;

    assign press_up    = btn_up    & ~prev_up;
    assign press_down  = btn_down  & ~prev_down;
    assign press_left  = btn_left  & ~prev_left;
    assign press_right = btn_right & ~prev_right;
    assign press_sel   = btn_sel   & ~prev_sel;

`ifdef GRID_CURSOR_AUTOREPEAT_EN
    localparam int CW = $clog2(REPEAT_DLY + REPEAT_PER + 1);

    dir_t          held_dir;
    logic [CW-1:0] rep_cnt;
    logic          rep_phase;   // 0: waiting for first repeat, 1: periodic repeats
    logic          held_lvl;
    logic          others_high;
    logic          rep_fire;

    always_comb begin
        held_lvl    = 1'b0;
        others_high = 1'b0;
        case (held_dir)
            DIR_UP: begin
                held_lvl    = btn_up;
                others_high = btn_down | btn_left | btn_right;
            end
            DIR_DOWN: begin
                held_lvl    = btn_down;
                others_high = btn_up | btn_left | btn_right;
            end
            DIR_LEFT: begin
                held_lvl    = btn_left;
                others_high = btn_up | btn_down | btn_right;
            end
            DIR_RIGHT: begin
                held_lvl    = btn_right;
                others_high = btn_up | btn_down | btn_left;
            end
            default: begin
                held_lvl    = 1'b0;
                others_high = 1'b0;
            end
        endcase
        rep_fire = (held_dir != DIR_NONE) && held_lvl && !others_high &&
                   (rep_cnt == (rep_phase ? CW'(REPEAT_PER - 1) : CW'(REPEAT_DLY - 1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_dir  <= DIR_NONE;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (!en) begin
            held_dir  <= DIR_NONE;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (press_dir != DIR_NONE) begin
            held_dir  <= press_dir;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (held_dir != DIR_NONE) begin
            if (!held_lvl || others_high) begin
                held_dir  <= DIR_NONE;
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        press_dir = DIR_NONE;
        if (en) begin
            if (press_up)         press_dir = DIR_UP;
            else if (press_down)  press_dir = DIR_DOWN;
            else if (press_left)  press_dir = DIR_LEFT;
            else if (press_right) press_dir = DIR_RIGHT;
        end
        move_dir = press_dir;
`ifdef GRID_CURSOR_AUTOREPEAT_EN
        if (en && press_dir == DIR_NONE && rep_fire) move_dir = held_dir;
`endif
        next_x  = cursor_x;
        next_y  = cursor_y;
        do_move = 1'b0;
        // An edge move either wraps to the far edge or is dropped without a moved pulse.
        case (move_dir)
            DIR_UP: begin
                if (cursor_y != '0) begin
                    next_y  = cursor_y - 1'b1;
                    do_move = 1'b1;
                end else if (WRAP != 0) begin
                    next_y  = YW'(ROWS - 1);
                    do_move = 1'b1;
                end
            end
            DIR_DOWN: begin
                if (cursor_y != YW'(ROWS - 1)) begin
                    next_y  = cursor_y + 1'b1;
                    do_move = 1'b1;
                end else if (WRAP != 0) begin
                    next_y  = '0;
                    do_move = 1'b1;
                end
            end
            DIR_LEFT: begin
                if (cursor_x != '0) begin
                    next_x  = cursor_x - 1'b1;
                    do_move = 1'b1;
                end else if (WRAP != 0) begin
                    next_x  = XW'(COLS - 1);
                    do_move = 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (cursor_x != XW'(COLS - 1)) begin
                    next_x  = cursor_x + 1'b1;
                    do_move = 1'b1;
                end else if (WRAP != 0) begin
                    next_x  = '0;
                    do_move = 1'b1;
                end
            end
            default: begin
                next_x  = cursor_x;
                next_y  = cursor_y;
                do_move = 1'b0;
            end
        endcase
        next_idx = IW'(32'(next_y) * 32'(COLS) + 32'(next_x));
    end

    // Previous levels reset high so a button held through reset release is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_up    <= 1'b1;
            prev_down  <= 1'b1;
            prev_left  <= 1'b1;
            prev_right <= 1'b1;
            prev_sel   <= 1'b1;
            cursor_x   <= '0;
            cursor_y   <= '0;
            cursor_idx <= '0;
            moved      <= 1'b0;
            sel_pulse  <= 1'b0;
            sel_idx    <= '0;
        end else begin
            prev_up    <= btn_up;
            prev_down  <= btn_down;
            prev_left  <= btn_left;
            prev_right <= btn_right;
            prev_sel   <= btn_sel;
            if (do_move) begin
                cursor_x   <= next_x;
                cursor_y   <= next_y;
                cursor_idx <= next_idx;
            end
            moved     <= do_move;
            sel_pulse <= en & press_sel;
            if (en && press_sel) sel_idx <= cursor_idx;
        end
    end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Randomized bench for grid_cursor_ctrl: a saturating and a wrapping instance share stimulus and
// are checked every cycle against a coordinate-level reference model.
module tb_grid_cursor_ctrl;

    localparam int C = 3;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;

    logic [2:0] x0, x1;
    logic [3:0] y0, y1;
    logic [3:0] i0, i1;
    logic       mv0, mv1, sp0, sp1;
    logic [3:0] si0, si1;

    int checks = 0;
    int errors = 0;

    int mx[2], my[2], msi[2];
    bit mmv[2];
    bit msp;
    bit prv[5];

    always #5 clk = ~clk;

    grid_cursor_ctrl #(.WRAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .cursor_x(x0), .cursor_y(y0), .cursor_idx(i0),
        .moved(mv0), .sel_pulse(sp0), .sel_idx(si0)
    );

    grid_cursor_ctrl #(.WRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .cursor_x(x1), .cursor_y(y1), .cursor_idx(i1),
        .moved(mv1), .sel_pulse(sp1), .sel_idx(si1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            mx[w] = 0; my[w] = 0; msi[w] = 0; mmv[w] = 1'b0;
        end
        msp = 1'b0;
        for (int i = 0; i < 5; i++) prv[i] = 1'b1;
    endtask

    // b: {sel, right, left, down, up}
    task automatic model_step(input logic [4:0] b, input bit e);
        bit pr[5];
        int d, nx, ny;
        for (int i = 0; i < 5; i++) begin
            pr[i]  = b[i] && !prv[i];
            prv[i] = b[i];
        end
        msp = e && pr[4];
        d = -1;
        if (e) for (int i = 3; i >= 0; i--) if (pr[i]) d = i;
        for (int w = 0; w < 2; w++) begin
            if (msp) msi[w] = my[w] * C + mx[w];
            nx = mx[w] + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
            ny = my[w] + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
            if (nx < 0 || nx >= C || ny < 0 || ny >= R) begin
                if (w == 1) begin
                    nx = (nx + C) % C;
                    ny = (ny + R) % R;
                end else begin
                    nx = mx[w];
                    ny = my[w];
                end
            end
            mmv[w] = (nx != mx[w]) || (ny != my[w]);
            mx[w]  = nx;
            my[w]  = ny;
        end
    endtask

    task automatic compare_all();
        check("x0",   int'(x0),  mx[0]);
        check("y0",   int'(y0),  my[0]);
        check("idx0", int'(i0),  my[0] * C + mx[0]);
        check("mv0",  int'(mv0), int'(mmv[0]));
        check("sp0",  int'(sp0), int'(msp));
        check("si0",  int'(si0), msi[0]);
        check("x1",   int'(x1),  mx[1]);
        check("y1",   int'(y1),  my[1]);
        check("idx1", int'(i1),  my[1] * C + mx[1]);
        check("mv1",  int'(mv1), int'(mmv[1]));
        check("sp1",  int'(sp1), int'(msp));
        check("si1",  int'(si1), msi[1]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_x0"},  int'(x0),  0);
        check({tag, "_y0"},  int'(y0),  0);
        check({tag, "_i0"},  int'(i0),  0);
        check({tag, "_mv0"}, int'(mv0), 0);
        check({tag, "_sp0"}, int'(sp0), 0);
        check({tag, "_si0"}, int'(si0), 0);
        check({tag, "_x1"},  int'(x1),  0);
        check({tag, "_y1"},  int'(y1),  0);
        check({tag, "_i1"},  int'(i1),  0);
        check({tag, "_si1"}, int'(si1), 0);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
    task automatic step(input logic [4:0] b, input bit e);
        btn_up    = b[0];
        btn_down  = b[1];
        btn_left  = b[2];
        btn_right = b[3];
        btn_sel   = b[4];
        en        = e;
        @(posedge clk);
        model_step(b, e);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Three right pulses: saturating instance stops at x=2.
        for (int k = 0; k < 3; k++) begin
            step(5'b01000, 1'b1);
            step(5'b00000, 1'b1);
        end
        check("right3_idx0", int'(i0), 2);

        // Simultaneous up+left from (1,2)-ish positions and select-with-move combos.
        step(5'b00010, 1'b1); step(5'b00000, 1'b1);
        step(5'b00010, 1'b1); step(5'b00000, 1'b1);
        step(5'b00101, 1'b1); step(5'b00000, 1'b1);
        step(5'b10010, 1'b1); step(5'b00000, 1'b1);

        // Randomized levels with occasional en=0.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] b;
            bit e;
            for (int i = 0; i < 5; i++) b[i] = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 7) != 0);
            step(b, e);
        end

        // Asynchronous reset mid-run with btn_down held through release.
        btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
        btn_down = 1'b1; en = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(5'b00010, 1'b1);
        step(5'b00010, 1'b1);
        step(5'b00010, 1'b1);
        check("hold_y0", int'(y0), 0);
        step(5'b00000, 1'b1);
        step(5'b00010, 1'b1);
        check("repress_y0", int'(y0), 1);
        check("repress_y1", int'(y1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/grid_cursor_ctrl.md
GRID_CURSOR_CTRL -- requirements
Module: grid_cursor_ctrl

Interface
REQ-001 Parameter COLS, default 3: grid column count; legal range 2..2^XW.
REQ-002 Parameter ROWS, default 4: grid row count; legal range 2..2^YW.
REQ-003 Parameter XW, default 3: cursor_x width in bits.
REQ-004 Parameter YW, default 4: cursor_y width in bits.
REQ-005 Parameter IW, default 4: cursor_idx and sel_idx width; must satisfy 2^IW >= COLS*ROWS.
REQ-006 Parameter WRAP, default 0: 0 saturates at the edges, 1 wraps to the opposite edge.
REQ-007 Ports, in order:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  move/select enable.
- btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  synchronous, pre-debounced button levels.
- cursor_x  out  XW  column.
- cursor_y  out  YW  row.
- cursor_idx  out  IW  registered value y*COLS+x.
- moved  out  1  one-cycle pulse on each position change.
- sel_pulse  out  1  one-cycle select strobe.
- sel_idx  out  IW  position captured for the select.

Function
REQ-008 The block SHALL register the previous level of each button; a press event is current level 1 with previous level 0.
REQ-009 A press event sampled at clock edge k SHALL update cursor_x/cursor_y, cursor_idx and moved at edge k (one-register latency).
REQ-010 At most one move SHALL be applied per cycle, with priority up > down > left > right; lower-priority simultaneous events SHALL be discarded, not queued.
REQ-011 Up SHALL decrement y, down increment y, left decrement x, right increment x.
REQ-012 With WRAP=0, a move past an edge (y=0 up, y=ROWS-1 down, x=0 left, x=COLS-1 right) SHALL leave the position unchanged and moved SHALL stay 0.
REQ-013 With WRAP=1, the same moves SHALL wrap (y=0 up -> ROWS-1, x=COLS-1 right -> 0, and so on) and moved SHALL pulse.
REQ-014 A press event on btn_sel SHALL assert sel_pulse for one cycle and load sel_idx with the pre-update cursor_idx; if a move occurs in the same cycle, the select reports the old position.
REQ-015 sel_idx SHALL hold its value until the next select.
REQ-016 While en=0:
- no move or select SHALL occur;
- the previous-level registers SHALL keep tracking the buttons;
- the repeat logic SHALL be cleared.
REQ-017 cursor_idx SHALL always equal cursor_y*COLS+cursor_x; position SHALL never leave 0..COLS-1 / 0..ROWS-1.

Reset
REQ-018 Asynchronous assertion of rst_n=0 SHALL immediately force the following, regardless of any operation in progress:
- cursor_x=0, cursor_y=0, cursor_idx=0;
- moved=0, sel_pulse=0, sel_idx=0;
- repeat counter=0;
- all previous-level registers=1.
REQ-019 Because the previous-level registers reset to 1, a button held high through reset release SHALL NOT generate a press event until it is released and pressed again.

Configuration
REQ-020 Macro GRID_CURSOR_AUTOREPEAT_EN SHALL, when defined, enable auto-repeat, with parameters REPEAT_DLY (default 50) and REPEAT_PER (default 10), in cycles.
REQ-021 With auto-repeat enabled:
- the direction that caused the last move SHALL become the held direction;
- if it stays high with no other direction button high, a repeat move SHALL occur REPEAT_DLY cycles after the initial press, then every REPEAT_PER cycles;
- repeat moves SHALL obey REQ-012/REQ-013.
REQ-022 Releasing the held button, pressing any other direction, en=0, or reset SHALL clear the repeat counter and the held direction.
REQ-023 A saturated repeat attempt under WRAP=0 SHALL keep counting without changing position.
REQ-024 Without the macro, no repeat logic or repeat parameters SHALL exist, and a held button SHALL cause exactly one move.

Verification
REQ-025 Reset, then pulse btn_right three times with defaults -> x=1, 2, 2; moved pulses twice; cursor_idx=2.
REQ-026 Raise btn_up and btn_left in the same cycle at (x=1, y=2) -> y=1, x=1, one moved pulse; the left press is lost.
REQ-027 WRAP=1, at (0,0) press up then left -> (0,3) then (2,3); cursor_idx=11; moved pulses each time.
REQ-028 At (2,1), press btn_sel and btn_down together -> sel_pulse=1, sel_idx=5, cursor moves to (2,2), cursor_idx=8.
REQ-029 Hold btn_down through reset release -> no move; release, press -> y=1.
REQ-030 With GRID_CURSOR_AUTOREPEAT_EN, REPEAT_DLY=4, REPEAT_PER=2, hold btn_right from (0,0) under WRAP=0 -> x=1 at edge k, x=2 at k+4, no further change at k+6 or k+8.
